uart8_tx_fifo: RTL and testbench

UART8_TX_FIFO -- requirements
Module: uart8_tx_fifo

---
 rtl/uart8_pkg.sv | 12 +
 rtl/sync_ff2.sv | 23 ++
 rtl/uart8_tx_fifo.sv | 107 ++++++++++
 tb/tb_uart8_tx_fifo.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart8_pkg.sv
// rtl/uart8_pkg.sv - shared FSM state type and default depth for the UART8 TX FIFO
package uart8_pkg;

    localparam int UART8_DEFAULT_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2
    } txState_t;

endpackage

// File: rtl/sync_ff2.sv
// rtl/sync_ff2.sv - 1-bit two-flop synchronizer with configurable reset value
module sync_ff2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rstN,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart8_tx_fifo.sv
// rtl/uart8_tx_fifo.sv - byte FIFO feeding a UART transmitter through a valid/ready handshake
module uart8_tx_fifo
    import uart8_pkg::*;
#(
    parameter int DEPTH = UART8_DEFAULT_DEPTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rstN,
    input  logic [7:0]    wrData,
    input  logic          wrValid,
    output logic          wrReady,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full,
    output logic [7:0]    txData,
    output logic          txValid,
    input  logic          txReady
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [AW:0]   countQ;
    txState_t      state;
    logic          txReadyS;
    logic          wrAccept;
    logic          pop;

    sync_ff2 #(
        .RESET_VAL (1'b1)
    ) u_txReadySync (
        .clk  (clk),
        .rstN (rstN),
        .d    (txReady),
        .q    (txReadyS)
    );

    assign count    = countQ;
    assign full     = (countQ == FULL_COUNT);
    assign empty    = (countQ == '0);
    assign wrReady  = !full;
    assign wrAccept = wrValid && !full;
    // The head leaves the FIFO when the transmitter signals it has taken the byte.
    assign pop      = (state == SEND) && !txReadyS;

    always_ff @(posedge clk) begin
        if (wrAccept) begin
            mem[wrPtr] <= wrData;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wrPtr  <= '0;
            countQ <= '0;
        end else begin
            if (wrAccept) begin
                wrPtr <= wrPtr + AW'(1);
            end
            case ({wrAccept, pop})
                2'b10:   countQ <= countQ + (AW+1)'(1);
                2'b01:   countQ <= countQ - (AW+1)'(1);
                default: countQ <= countQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state   <= IDLE;
            txValid <= 1'b0;
            txData  <= 8'h00;
            rdPtr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty && txReadyS) begin
                        txData  <= mem[rdPtr];
                        txValid <= 1'b1;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (!txReadyS) begin
                        txValid <= 1'b0;
                        rdPtr   <= rdPtr + AW'(1);
                        state   <= DRAIN;
                    end
                end
                DRAIN: begin
                    txValid <= 1'b0;
                    if (txReadyS) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    txValid <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart8_tx_fifo.sv
// tb/tb_uart8_tx_fifo.sv - scoreboard bench for uart8_tx_fifo with a randomized transmitter model
module tb_uart8_tx_fifo;
    import uart8_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic          clk;
    logic          rstN;
    logic [7:0]    wrData;
    logic          wrValid;
    logic          wrReady;
    logic [AW:0]   count;
    logic          empty;
    logic          full;
    logic [7:0]    txData;
    logic          txValid;
    logic          txReady;

    logic          txAuto;
    logic          autoReady;
    logic          txManual;

    int            checks;
    int            failures;
    int            modelCount;
    int            rxCount;
    logic [7:0]    expQ [$];
    logic          prevValid;
    logic [7:0]    heldData;

    assign txReady = txAuto ? autoReady : txManual;

    uart8_tx_fifo #(
        .DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .rstN    (rstN),
        .wrData  (wrData),
        .wrValid (wrValid),
        .wrReady (wrReady),
        .count   (count),
        .empty   (empty),
        .full    (full),
        .txData  (txData),
        .txValid (txValid),
        .txReady (txReady)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Reference: occupancy rises on each accepted write and falls on each completed transmission.
    always @(negedge clk) begin
        if (!rstN) begin
            prevValid = 1'b0;
        end else begin
            if (txValid && !prevValid) begin
                rxCount++;
                if (expQ.size() == 0) begin
                    check("tx_unexpected_byte", int'(txData), -1);
                end else begin
                    check("tx_byte_order", int'(txData), int'(expQ.pop_front()));
                end
                heldData = txData;
            end else if (txValid && prevValid) begin
                check("tx_data_stable", int'(txData), int'(heldData));
            end else if (!txValid && prevValid) begin
                modelCount--;
            end
            check("count", int'(count), modelCount);
            check("empty", int'(empty), int'(modelCount == 0));
            check("full", int'(full), int'(modelCount == DEPTH));
            check("wrReady", int'(wrReady), int'(modelCount < DEPTH));
            prevValid = txValid;
        end
    end

    always @(negedge clk) begin
        if (txAuto && txValid && autoReady) begin
            autoReady = 1'b0;
            repeat ($urandom_range(3, 20)) @(negedge clk);
            autoReady = 1'b1;
        end
    end

    task automatic writeByte(input logic [7:0] b);
        wrData  = b;
        wrValid = 1'b1;
        @(posedge clk);
        if (modelCount < DEPTH) begin
            expQ.push_back(b);
            modelCount++;
        end
        #1;
        wrValid = 1'b0;
    endtask

    task automatic applyReset();
        rstN = 1'b0;
        #1;
        expQ.delete();
        modelCount = 0;
        repeat (2) @(posedge clk);
        #1;
        rstN = 1'b1;
    endtask

    task automatic waitDrain(input string name, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (expQ.size() == 0 && modelCount == 0 && !txValid) begin
                done = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check(name, int'(done), 1);
    endtask

    task automatic waitTxValid(input string name, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (txValid) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check(name, int'(seen), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rxStart;
        checks     = 0;
        failures   = 0;
        modelCount = 0;
        rxCount    = 0;
        prevValid  = 1'b0;
        heldData   = 8'h00;
        rstN       = 1'b0;
        wrData     = 8'h00;
        wrValid    = 1'b0;
        txAuto     = 1'b0;
        autoReady  = 1'b1;
        txManual   = 1'b1;

        // Reset state
        applyReset();
        check("rst_count", int'(count), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_wrReady", int'(wrReady), 1);
        check("rst_txValid", int'(txValid), 0);
        check("rst_txData", int'(txData), 0);
        check("rst_state", int'(dut.state), int'(IDLE));

        // Single byte and first-transaction latency
        writeByte(8'hA5);
        check("lat_noValid_N", int'(txValid), 0);
        @(posedge clk);
        #1;
        check("lat_valid_N1", int'(txValid), 1);
        check("lat_data_N1", int'(txData), 8'hA5);
        txManual = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("single_count", int'(count), 0);
        check("single_txValid", int'(txValid), 0);
        txManual = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("single_state_idle", int'(dut.state), int'(IDLE));
        check("single_no_dup", int'(txValid), 0);

        // Fill to full with the transmitter held busy
        applyReset();
        txManual = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) writeByte(8'(i));
        check("fill_full", int'(full), 1);
        check("fill_count", int'(count), 16);
        writeByte(8'd16);
        check("fill_reject_count", int'(count), 16);
        check("fill_reject_wrReady", int'(wrReady), 0);
        check("fill_reject_model", expQ.size(), 16);
        txAuto = 1'b1;
        waitDrain("fill_drain_timeout", 2000);
        txAuto = 1'b0;
        txManual = 1'b1;

        // Ordered stream through random busy periods, wrapping the pointers
        txAuto  = 1'b1;
        rxStart = rxCount;
        for (int i = 0; i < 40; i++) begin
            for (int w = 0; w < 1000 && modelCount >= DEPTH; w++) begin
                @(posedge clk);
                #1;
            end
            writeByte(8'(i));
        end
        waitDrain("order_drain_timeout", 3000);
        check("order_rx_total", rxCount - rxStart, 40);

        // Random bytes with random gaps, including writes offered while full
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end else begin
                writeByte(8'($urandom));
            end
        end
        waitDrain("random_drain_timeout", 3000);
        txAuto = 1'b0;

        // Write on the same edge as the SEND->DRAIN pop with one entry stored
        applyReset();
        txManual = 1'b1;
        writeByte(8'h77);
        @(posedge clk);
        #1;
        check("simul_in_send", int'(dut.state), int'(SEND));
        txManual = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        writeByte(8'h3C);
        check("simul_count", int'(count), 1);
        check("simul_state_drain", int'(dut.state), int'(DRAIN));
        txManual = 1'b1;
        waitTxValid("simul_next_timeout", 50);
        check("simul_next_byte", int'(txData), 8'h3C);
        txAuto = 1'b1;
        waitDrain("simul_drain_timeout", 200);
        txAuto = 1'b0;

        // Reset while a transfer is in SEND
        applyReset();
        txManual = 1'b1;
        for (int i = 0; i < 5; i++) writeByte(8'h50 + 8'(i));
        check("midrst_in_send", int'(dut.state), int'(SEND));
        rstN = 1'b0;
        #1;
        check("midrst_txValid", int'(txValid), 0);
        check("midrst_count", int'(count), 0);
        expQ.delete();
        modelCount = 0;
        repeat (2) @(posedge clk);
        #1;
        rstN = 1'b1;
        writeByte(8'h11);
        waitTxValid("midrst_after_timeout", 50);
        check("midrst_after_byte", int'(txData), 8'h11);
        txAuto = 1'b1;
        waitDrain("midrst_drain_timeout", 200);
        txAuto = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
